cmos_pixel_capture: RTL
=======================

// Module: cmos_pixel_capture
// PURPOSE
//  Camera-side front end: converts OV-style DVP byte stream (vsync/href/8-bit data, pclk domain)
//  into 16-bit RGB565 pixels with frame start/end markers. Sits between the camera pins and the
//  SDRAM frame-buffer controller write port. Drops settling frames after config and flags short frames.
// PARAMETERS
//  H_PIX        1280  active pixels per line; pixels beyond this in a line are dropped
//  V_PIX        720   active lines per frame; lines beyond this are dropped
//  SKIP_FRAMES  10    whole frames discarded after enable rises, before capture starts
// PORTS
//  clk        in   1   pixel clock (camera pclk after I/O buffer); single clock domain
//  rst_n      in   1   asynchronous active-low reset
//  enable     in   1   camera register configuration done; level
//  vsync      in   1   camera frame sync, active high, pulse at frame start
//  href       in   1   camera line valid, active high
//  din        in   8   camera data byte; high byte first, then low byte of RGB565
//  dout       out  16  RGB565 pixel
//  dout_vld   out  1   dout valid, 1-cycle strobe per pixel; no backpressure
//  dout_sop   out  1   with dout_vld, first pixel (x=0,y=0) of frame
//  dout_eop   out  1   with dout_vld, last pixel (x=H_PIX-1,y=V_PIX-1) of frame
//  frame_err  out  1   1-cycle pulse: new vsync arrived before eop of current frame
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, counters 0, byte phase 0.
//  - Input stage: vsync/href/din registered once (vs_r1, href_r, din_r); vs_r2 delays vs_r1.
//    vs_rise = vs_r1 & ~vs_r2.
//  - FSM: IDLE: enable=1 -> SKIP, skip_cnt=0.
//    SKIP: each vs_rise: if skip_cnt==SKIP_FRAMES -> CAPT else skip_cnt+1. SKIP_FRAMES=0 -> first
//    vs_rise enters CAPT. CAPT: stays until enable=0.
//    enable=0 in any state -> IDLE next cycle; counters/byte phase cleared; no further dout_vld.
//  - Byte pairing (CAPT only): byte phase toggles every cycle href_r=1; cleared whenever href_r=0.
//    Phase 0 latches din_r into dout[15:8]; phase 1 forms pixel {hi,din_r}. Odd trailing byte
//    at line end discarded.
//  - Latency: low byte at pins on cycle t -> dout/dout_vld on cycle t+2.
//  - Counters: x in 0..H_PIX-1 increments per pixel; on href_r falling edge x=0 and y+1 if x!=0.
//    Pixel emitted (dout_vld=1) only when x<H_PIX and y<V_PIX; otherwise dropped, counters
//    saturate (x at H_PIX, y at V_PIX).
//  - dout_sop = dout_vld & x==0 & y==0; dout_eop = dout_vld & x==H_PIX-1 & y==V_PIX-1.
//  - vs_rise in CAPT: x,y cleared, byte phase cleared. frame_err pulses 1 cycle if an sop of the
//    current frame was emitted but its eop was not. No error for the first vs_rise entering CAPT.
//  - Simultaneous vs_rise and pixel strobe: pixel is emitted with old counters, then clear applies.
//  - Counter widths: $clog2(H_PIX+1), $clog2(V_PIX+1).
// CONFIGURATION
//  CAP_TEST_PATTERN_EN defined: dout replaced by 8 vertical colour bars, bar = x/(H_PIX/8):
//    FFFF,FFE0,07FF,07E0,F81F,F800,001F,0000; timing, vld/sop/eop/frame_err unchanged; din ignored.
//  Not defined: dout = camera RGB565 as paired above.
// TESTING
//  1 Reset: rst_n=0 mid-frame -> all outputs 0 same cycle; after release no dout_vld until enable.
//  2 Skip: SKIP_FRAMES=2, enable=1, 4 full frames -> frames 1,2 dropped; sop on frame 3 first pixel.
//  3 Pairing: H_PIX=4,V_PIX=2, bytes 12,34,56,78 -> dout 1234 then 5678, each 2 cycles after low
//    byte; eop on pixel (3,1).
//  4 Short frame: vsync after 1 of 2 lines -> frame_err pulse 1 cycle; next frame sop at (0,0).
//  5 Over-size: line of 6 pixels, H_PIX=4 -> 4 vld strobes; 3 lines, V_PIX=2 -> 3rd line dropped.
//  6 CAP_TEST_PATTERN_EN, H_PIX=16: pixel x=0 -> FFFF, x=2 -> FFE0, x=15 -> 0000.

Source files
------------

// File: rtl/cmos_pixel_capture.sv
// -----------------------------------------------------------------------------
// cmos_pixel_capture
//
// Camera-side front end. Converts an OV-style DVP byte stream (vsync / href /
// 8-bit data, all in the pixel clock domain) into 16-bit RGB565 pixels that
// carry start-of-frame / end-of-frame markers. The SDRAM frame-buffer write
// port consumes these pixels. After the camera is configured, the block
// discards a number of settling frames. It also flags frames that end early.
//
// Parameters
//   H_PIX        active pixels per line; any further pixels in a line are dropped
//   V_PIX        active lines per frame; any further lines are dropped
//   SKIP_FRAMES  whole frames discarded after enable rises, before capture starts
//
// Ports
//   clk        in   pixel clock (camera pclk after the I/O buffer)
//   rst_n      in   asynchronous active-low reset
//   enable     in   camera configuration done (level); low forces IDLE
//   vsync      in   frame sync, active high, pulses at the start of each frame
//   href       in   line valid, active high
//   din[7:0]   in   camera byte: high byte of the RGB565 word first, then the low byte
//   dout[15:0] out  RGB565 pixel
//   dout_vld   out  one-cycle strobe per pixel (no backpressure)
//   dout_sop   out  with dout_vld: pixel (0,0) of the frame
//   dout_eop   out  with dout_vld: pixel (H_PIX-1,V_PIX-1) of the frame
//   frame_err  out  one-cycle pulse: new vsync arrived before the current frame's eop
//
// Build option
//   CAP_TEST_PATTERN_EN  when defined, dout carries 8 vertical colour bars
//                        (bar = x / (H_PIX/8)) in place of camera data. Timing
//                        and all strobes stay unchanged, and din is ignored.
// -----------------------------------------------------------------------------
module cmos_pixel_capture #(
   parameter int H_PIX       = 1280,
   parameter int V_PIX       = 720,
   parameter int SKIP_FRAMES = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        vsync,
   input  logic        href,
   input  logic [7:0]  din,
   output logic [15:0] dout,
   output logic        dout_vld,
   output logic        dout_sop,
   output logic        dout_eop,
   output logic        frame_err
);

   localparam int XW = $clog2(H_PIX + 1);
   localparam int YW = $clog2(V_PIX + 1);
   localparam int SW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

   localparam logic [XW-1:0] X_LIM  = XW'(H_PIX);
   localparam logic [XW-1:0] X_LAST = XW'(H_PIX - 1);
   localparam logic [YW-1:0] Y_LIM  = YW'(V_PIX);
   localparam logic [YW-1:0] Y_LAST = YW'(V_PIX - 1);
   localparam logic [SW-1:0] SKIP_LAST = SW'(SKIP_FRAMES);

`ifdef CAP_TEST_PATTERN_EN
   // Guard against H_PIX < 8 so that the bar width never becomes zero.
   localparam logic [XW-1:0] X_BAR_DIV = XW'((H_PIX >= 8) ? (H_PIX / 8) : 1);

   // Colour of each of the 8 vertical bars, from left to right.
   function automatic logic [15:0] bar_colour(input logic [2:0] bar);
      logic [15:0] c;
      case (bar)
         3'd0:    c = 16'hFFFF;
         3'd1:    c = 16'hFFE0;
         3'd2:    c = 16'h07FF;
         3'd3:    c = 16'h07E0;
         3'd4:    c = 16'hF81F;
         3'd5:    c = 16'hF800;
         3'd6:    c = 16'h001F;
         default: c = 16'h0000;
      endcase
      return c;
   endfunction
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SKIP = 2'd1,
      ST_CAPT = 2'd2
   } state_t;

   state_t state_q, state_d;

   // Input stage registers
   logic          vs_r1_q, vs_r1_d;
   logic          vs_r2_q, vs_r2_d;
   logic          href_r_q, href_r_d;
   logic          href_d1_q, href_d1_d;
   logic [7:0]    din_r_q, din_r_d;

   // Capture datapath registers
   logic [SW-1:0] skip_cnt_q, skip_cnt_d;
   logic          phase_q, phase_d;
   logic [7:0]    hi_q, hi_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          sop_seen_q, sop_seen_d;

   // Output registers
   logic [15:0]   dout_q, dout_d;
   logic          dout_vld_q, dout_vld_d;
   logic          dout_sop_q, dout_sop_d;
   logic          dout_eop_q, dout_eop_d;
   logic          frame_err_q, frame_err_d;

   // Decoded events
   logic          vs_rise;
   logic          href_fall;
   logic          in_capt;
   logic          pix_stb;
   logic          in_window;
   logic          emit;
   logic          is_sop;
   logic          is_eop;
   logic [15:0]   pix_val;
`ifdef CAP_TEST_PATTERN_EN
   logic [XW-1:0] bar_idx;
   logic [2:0]    bar_sel;
`endif

   // Input stage: register the pins once and build the edge detectors
   always_comb begin
      vs_r1_d   = vsync;
      vs_r2_d   = vs_r1_q;
      href_r_d  = href;
      href_d1_d = href_r_q;
      din_r_d   = din;

      vs_rise   = vs_r1_q & ~vs_r2_q;
      href_fall = href_d1_q & ~href_r_q;
   end

   // Pixel strobe, window test and frame-marker decode
   always_comb begin
      // A falling enable stops pixel output in that same cycle. Pixel output
      // does not wait for the state to reach IDLE.
      in_capt   = (state_q == ST_CAPT) & enable;
      // Phase 1 means din_r holds the low byte and hi_q holds the high byte.
      pix_stb   = in_capt & href_r_q & phase_q;
      in_window = (x_q < X_LIM) & (y_q < Y_LIM);
      emit      = pix_stb & in_window;
      is_sop    = emit & (x_q == '0) & (y_q == '0);
      is_eop    = emit & (x_q == X_LAST) & (y_q == Y_LAST);
   end

   // Pixel value: camera pair or colour-bar test pattern
`ifdef CAP_TEST_PATTERN_EN
   always_comb begin
      bar_idx = x_q / X_BAR_DIV;
      if (bar_idx > XW'(7)) begin
         bar_sel = 3'd7;
      end else begin
         bar_sel = bar_idx[2:0];
      end
      pix_val = bar_colour(bar_sel);
   end
`else
   always_comb begin
      pix_val = {hi_q, din_r_q};
   end
`endif

   // FSM next-state logic together with the counter, byte-phase and output next values
   always_comb begin
      state_d     = state_q;
      skip_cnt_d  = skip_cnt_q;
      phase_d     = phase_q;
      hi_d        = hi_q;
      x_d         = x_q;
      y_d         = y_q;
      sop_seen_d  = sop_seen_q;
      dout_d      = dout_q;
      dout_vld_d  = 1'b0;
      dout_sop_d  = 1'b0;
      dout_eop_d  = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d    = ST_SKIP;
               skip_cnt_d = '0;
            end else begin
               state_d    = ST_IDLE;
            end
         end
         ST_SKIP: begin
            if (vs_rise) begin
               if (skip_cnt_q == SKIP_LAST) begin
                  // This vsync opens the first captured frame. A frame_err
                  // is not possible here.
                  state_d    = ST_CAPT;
                  x_d        = '0;
                  y_d        = '0;
                  phase_d    = 1'b0;
                  sop_seen_d = 1'b0;
               end else begin
                  skip_cnt_d = skip_cnt_q + SW'(1);
               end
            end else begin
               state_d = ST_SKIP;
            end
         end
         ST_CAPT: begin
            state_d = ST_CAPT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (in_capt) begin
         // The byte phase runs only while href is high. A low href between
         // lines realigns the phase, which drops an odd trailing byte.
         if (href_r_q) begin
            phase_d = ~phase_q;
         end else begin
            phase_d = 1'b0;
         end

         if (href_r_q & ~phase_q) begin
            hi_d = din_r_q;
         end else begin
            hi_d = hi_q;
         end

         // x saturates at H_PIX, so any extra pixels in a line are dropped.
         // A line end clears x. It advances y only if the line held pixels.
         if (pix_stb) begin
            if (x_q < X_LIM) begin
               x_d = x_q + XW'(1);
            end else begin
               x_d = x_q;
            end
         end else if (href_fall) begin
            x_d = '0;
            if ((x_q != '0) && (y_q < Y_LIM)) begin
               y_d = y_q + YW'(1);
            end else begin
               y_d = y_q;
            end
         end else begin
            x_d = x_q;
         end

         if (emit) begin
            dout_d     = pix_val;
            dout_vld_d = 1'b1;
            dout_sop_d = is_sop;
            dout_eop_d = is_eop;
         end else begin
            dout_d     = dout_q;
         end

         if (is_eop) begin
            sop_seen_d = 1'b0;
         end else if (is_sop) begin
            sop_seen_d = 1'b1;
         end else begin
            sop_seen_d = sop_seen_q;
         end

         // A new frame is starting. Any pixel strobed in this cycle has
         // already used the old counters above, so the clear can override them.
         if (vs_rise) begin
            frame_err_d = (sop_seen_q | is_sop) & ~is_eop;
            x_d         = '0;
            y_d         = '0;
            phase_d     = 1'b0;
            sop_seen_d  = 1'b0;
         end else begin
            frame_err_d = 1'b0;
         end
      end else begin
         frame_err_d = 1'b0;
      end

      // Dropping the configuration-done level abandons everything.
      if (!enable) begin
         state_d    = ST_IDLE;
         skip_cnt_d = '0;
         phase_d    = 1'b0;
         x_d        = '0;
         y_d        = '0;
         sop_seen_d = 1'b0;
      end else begin
         sop_seen_d = sop_seen_d;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Input stage registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_r1_q   <= 1'b0;
         vs_r2_q   <= 1'b0;
         href_r_q  <= 1'b0;
         href_d1_q <= 1'b0;
         din_r_q   <= 8'h00;
      end else begin
         vs_r1_q   <= vs_r1_d;
         vs_r2_q   <= vs_r2_d;
         href_r_q  <= href_r_d;
         href_d1_q <= href_d1_d;
         din_r_q   <= din_r_d;
      end
   end

   // Capture datapath registers: skip count, byte phase, counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skip_cnt_q <= '0;
         phase_q    <= 1'b0;
         hi_q       <= 8'h00;
         x_q        <= '0;
         y_q        <= '0;
         sop_seen_q <= 1'b0;
      end else begin
         skip_cnt_q <= skip_cnt_d;
         phase_q    <= phase_d;
         hi_q       <= hi_d;
         x_q        <= x_d;
         y_q        <= y_d;
         sop_seen_q <= sop_seen_d;
      end
   end

   // Output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_q      <= 16'h0000;
         dout_vld_q  <= 1'b0;
         dout_sop_q  <= 1'b0;
         dout_eop_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         dout_q      <= dout_d;
         dout_vld_q  <= dout_vld_d;
         dout_sop_q  <= dout_sop_d;
         dout_eop_q  <= dout_eop_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign dout      = dout_q;
   assign dout_vld  = dout_vld_q;
   assign dout_sop  = dout_sop_q;
   assign dout_eop  = dout_eop_q;
   assign frame_err = frame_err_q;

endmodule
